unit_ce_sequencer: RTL and testbench

- Controller that sequences a mapped unit-under-test: drives its reset and clock-enable (ce), and monitors its 2-bit dout and debug outputs.
- Runs a programmed pattern: unit reset phase, then N bursts of ce-high cycles separated by idle gaps.
- Sits between the co-simulation stimulus layer and the synthesized unit, so benches drive one start pulse instead of hand-toggling ce and reset.

---
 rtl/unit_ce_sequencer_pkg.sv | 15 +
 rtl/unit_ce_sequencer_monitor.sv | 48 ++++
 rtl/unit_ce_sequencer.sv | 145 ++++++++++++++
 tb/tb_unit_ce_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/unit_ce_sequencer_pkg.sv
// Shared definitions for the unit clock-enable sequencer: FSM encoding and default widths.
package unit_ce_sequencer_pkg;

  localparam int CNT_W_DEF = 8;
  localparam int DBG_W_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RST,
    ST_BURST,
    ST_GAP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/unit_ce_sequencer_monitor.sv
// Observes the controlled unit: delays ce by one cycle, captures dout on the
// following cycle and keeps a saturating count of captured debug-high cycles.
module unit_ce_monitor
  import unit_ce_sequencer_pkg::*;
#(
  parameter int DBG_W = DBG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             unit_ce_i,
  input  logic [1:0]       unit_dout_i,
  input  logic             unit_debug_i,
  output logic [1:0]       last_dout_o,
  output logic [DBG_W-1:0] debug_count_o
);

  localparam logic [DBG_W-1:0] DBG_ONE = 1;
  localparam logic [DBG_W-1:0] DBG_MAX = '1;

  logic             ce_d_q;
  logic [1:0]       last_dout_q;
  logic [DBG_W-1:0] debug_count_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      ce_d_q        <= 1'b0;
      last_dout_q   <= 2'b00;
      debug_count_q <= '0;
    end else begin
      ce_d_q <= unit_ce_i;
      if (clear_i) begin
        last_dout_q   <= 2'b00;
        debug_count_q <= '0;
      end else if (ce_d_q) begin
        // The unit's response to a ce-high cycle is visible one cycle later.
        last_dout_q <= unit_dout_i;
        if (unit_debug_i && (debug_count_q != DBG_MAX)) begin
          debug_count_q <= debug_count_q + DBG_ONE;
        end
      end
    end
  end

  assign last_dout_o   = last_dout_q;
  assign debug_count_o = debug_count_q;

endmodule

// File: rtl/unit_ce_sequencer.sv
// Sequences a controlled unit: reset phase, then n_bursts bursts of ce-high
// cycles separated by gap_len idle cycles, with a one-cycle done pulse at the end.
module unit_ce_sequencer
  import unit_ce_sequencer_pkg::*;
#(
  parameter int RST_CYCLES = 4,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DBG_W      = DBG_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [CNT_W-1:0] burst_len,
  input  logic [CNT_W-1:0] gap_len,
  input  logic [CNT_W-1:0] n_bursts,
  input  logic [1:0]       unit_dout,
  input  logic             unit_debug,
  output logic             unit_ce,
  output logic             unit_reset,
  output logic             busy,
  output logic             done,
  output logic [1:0]       last_dout,
  output logic [DBG_W-1:0] debug_count
);

  // Phase counter is wide enough for both the reset phase and burst/gap lengths.
  localparam int RST_W = $clog2(RST_CYCLES + 1);
  localparam int PH_W  = (CNT_W > RST_W) ? CNT_W : RST_W;

  localparam logic [PH_W-1:0]  PH_ONE   = 1;
  localparam logic [PH_W-1:0]  RST_LAST = PH_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;

  state_t           state_q, state_d;
  logic [PH_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] burst_q, burst_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic             start_acc;

  logic unit_ce_q, unit_reset_q, busy_q, done_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    burst_d   = burst_q;
    gap_d     = gap_q;
    start_acc = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          start_acc = 1'b1;
          burst_d   = burst_len;
          gap_d     = gap_len;
          rem_d     = n_bursts;
          cnt_d     = RST_LAST;
          state_d   = ST_RST;
        end
      end
      ST_RST: begin
        if (cnt_q == '0) begin
          if ((rem_q == '0) || (burst_q == '0)) begin
            state_d = ST_DONE;
          end else begin
            cnt_d   = PH_W'(burst_q) - PH_ONE;
            state_d = ST_BURST;
          end
        end else begin
          cnt_d = cnt_q - PH_ONE;
        end
      end
      ST_BURST: begin
        if (cnt_q == '0) begin
          rem_d = rem_q - CNT_ONE;
          if (rem_q == CNT_ONE) begin
            state_d = ST_DONE;
          end else if (gap_q == '0) begin
            // Zero gap: ce stays high straight into the next burst.
            cnt_d = PH_W'(burst_q) - PH_ONE;
          end else begin
            cnt_d   = PH_W'(gap_q) - PH_ONE;
            state_d = ST_GAP;
          end
        end else begin
          cnt_d = cnt_q - PH_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) begin
          cnt_d   = PH_W'(burst_q) - PH_ONE;
          state_d = ST_BURST;
        end else begin
          cnt_d = cnt_q - PH_ONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rem_q        <= '0;
      burst_q      <= '0;
      gap_q        <= '0;
      unit_ce_q    <= 1'b0;
      unit_reset_q <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rem_q        <= rem_d;
      burst_q      <= burst_d;
      gap_q        <= gap_d;
      // Outputs are decoded from the next state so they line up with state_q.
      unit_ce_q    <= (state_d == ST_BURST);
      unit_reset_q <= (state_d == ST_IDLE) || (state_d == ST_RST);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_DONE);
    end
  end

  assign unit_ce    = unit_ce_q;
  assign unit_reset = unit_reset_q;
  assign busy       = busy_q;
  assign done       = done_q;

  unit_ce_monitor #(
    .DBG_W(DBG_W)
  ) u_monitor (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (start_acc),
    .unit_ce_i    (unit_ce_q),
    .unit_dout_i  (unit_dout),
    .unit_debug_i (unit_debug),
    .last_dout_o  (last_dout),
    .debug_count_o(debug_count)
  );

endmodule

// File: tb/tb_unit_ce_sequencer.sv
// Directed bench for unit_ce_sequencer; a second instance with a 4-bit debug
// counter shares the stimulus to exercise saturation.
module tb_unit_ce_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] burst_len, gap_len, n_bursts;
  logic [1:0] unit_dout;
  logic       unit_debug;

  logic        unit_ce, unit_reset, busy, done;
  logic [1:0]  last_dout;
  logic [15:0] debug_count;

  logic        b_ce, b_reset, b_busy, b_done;
  logic [1:0]  b_last_dout;
  logic [3:0]  b_debug_count;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  logic [31:0] ce_v, rst_v, busy_v, done_v;
  int pos;

  always #5 clk = ~clk;

  unit_ce_sequencer #(.RST_CYCLES(4), .CNT_W(8), .DBG_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
    .gap_len(gap_len), .n_bursts(n_bursts), .unit_dout(unit_dout),
    .unit_debug(unit_debug), .unit_ce(unit_ce), .unit_reset(unit_reset),
    .busy(busy), .done(done), .last_dout(last_dout), .debug_count(debug_count)
  );

  unit_ce_sequencer #(.RST_CYCLES(4), .CNT_W(8), .DBG_W(4)) dut_b (
    .clk(clk), .reset(reset), .start(start), .burst_len(burst_len),
    .gap_len(gap_len), .n_bursts(n_bursts), .unit_dout(unit_dout),
    .unit_debug(unit_debug), .unit_ce(b_ce), .unit_reset(b_reset),
    .busy(b_busy), .done(b_done), .last_dout(b_last_dout), .debug_count(b_debug_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Record one bit per cycle of each control output, then advance a cycle.
  task automatic cap(input int n);
    for (int i = 0; i < n; i++) begin
      ce_v[pos]   = unit_ce;
      rst_v[pos]  = unit_reset;
      busy_v[pos] = busy;
      done_v[pos] = done;
      pos++;
      step();
    end
  endtask

  task automatic clr_cap();
    ce_v = '0; rst_v = '0; busy_v = '0; done_v = '0; pos = 0;
  endtask

  task automatic launch(input logic [7:0] bl, input logic [7:0] gl, input logic [7:0] nb);
    burst_len = bl; gap_len = gl; n_bursts = nb;
    start = 1'b1;
    step();
    start = 1'b0;
    clr_cap();
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; burst_len = '0; gap_len = '0; n_bursts = '0;
    unit_dout = 2'b00; unit_debug = 1'b0;
    clr_cap();

    // Reset state
    step(); step(); step();
    chk("rst_unit_reset", 32'(unit_reset), 32'd1);
    chk("rst_unit_ce", 32'(unit_ce), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_debug_count", 32'(debug_count), 32'd0);
    chk("rst_last_dout", 32'(last_dout), 32'd0);
    reset = 1'b1;
    step();
    $display("txn reset: unit_reset=%0b unit_ce=%0b busy=%0b", unit_reset, unit_ce, busy);

    // Basic run: 3 on, 2 off, 2 bursts
    unit_dout = 2'b01;
    launch(8'd3, 8'd2, 8'd2);
    cap(14);
    chk("basic_ce", ce_v & 32'h3FFF, 32'h0E70);
    chk("basic_reset", rst_v & 32'h3FFF, 32'h200F);
    chk("basic_busy", busy_v & 32'h3FFF, 32'h1FFF);
    chk("basic_done", done_v & 32'h3FFF, 32'h1000);
    chk("basic_last_dout", 32'(last_dout), 32'd1);
    chk("basic_debug_count", 32'(debug_count), 32'd0);
    $display("txn basic: ce=0x%0h busy=0x%0h done=0x%0h", ce_v, busy_v, done_v);

    // Back-to-back bursts with zero gap, debug held high
    unit_debug = 1'b1;
    launch(8'd2, 8'd0, 8'd3);
    cap(12);
    chk("b2b_ce", ce_v & 32'hFFF, 32'h3F0);
    chk("b2b_done", done_v & 32'hFFF, 32'h400);
    chk("b2b_busy", busy_v & 32'hFFF, 32'h7FF);
    chk("b2b_debug_count", 32'(debug_count), 32'd6);
    chk("b2b_debug_count_w4", 32'(b_debug_count), 32'd6);
    $display("txn back_to_back: ce=0x%0h debug_count=%0d", ce_v, debug_count);

    // Degenerate: n_bursts = 0
    unit_debug = 1'b0;
    launch(8'd5, 8'd1, 8'd0);
    cap(6);
    chk("deg_n0_ce", ce_v & 32'h3F, 32'h0);
    chk("deg_n0_done", done_v & 32'h3F, 32'h10);
    chk("deg_n0_busy", busy_v & 32'h3F, 32'h1F);
    chk("deg_n0_debug_cleared", 32'(debug_count), 32'd0);
    $display("txn degenerate_n0: done=0x%0h", done_v);

    // Degenerate: burst_len = 0
    launch(8'd0, 8'd1, 8'd2);
    cap(6);
    chk("deg_b0_ce", ce_v & 32'h3F, 32'h0);
    chk("deg_b0_done", done_v & 32'h3F, 32'h10);
    $display("txn degenerate_b0: done=0x%0h", done_v);

    // Start ignored during BURST, then reset during GAP
    unit_dout = 2'b11;
    launch(8'd3, 8'd4, 8'd2);
    cap(5);
    start = 1'b1; burst_len = 8'd9;
    cap(1);
    start = 1'b0;
    cap(3);
    chk("ign_ce", ce_v & 32'h1FF, 32'h070);
    chk("ign_reset", rst_v & 32'h1FF, 32'h00F);
    chk("ign_last_dout", 32'(last_dout), 32'd3);
    reset = 1'b0;
    step();
    chk("midrst_unit_reset", 32'(unit_reset), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_unit_ce", 32'(unit_ce), 32'd0);
    chk("midrst_last_dout", 32'(last_dout), 32'd0);
    reset = 1'b1;
    clr_cap();
    cap(8);
    chk("midrst_no_done", done_v & 32'hFF, 32'h0);
    chk("midrst_no_ce", ce_v & 32'hFF, 32'h0);
    $display("txn start_ignored_midrst: ce=0x%0h done=0x%0h", ce_v, done_v);

    // Capture after last ce and debug saturation
    unit_dout = 2'b01; unit_debug = 1'b1;
    launch(8'd20, 8'd0, 8'd1);
    cap(24);
    unit_dout = 2'b10;
    cap(1);
    chk("sat_ce", ce_v & 32'h1FFFFFF, 32'h0FFFFF0);
    chk("sat_done", done_v & 32'h1FFFFFF, 32'h1000000);
    chk("sat_last_dout", 32'(last_dout), 32'd2);
    chk("sat_debug_count_w16", 32'(debug_count), 32'd20);
    chk("sat_debug_count_w4", 32'(b_debug_count), 32'd15);
    $display("txn capture_sat: last_dout=%0d dbg16=%0d dbg4=%0d", last_dout, debug_count, b_debug_count);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
